branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Branch/jump resolution stage: evaluates the execute-stage control transfer,
// raises traps, detects mispredicts, and squashes the shadow of any redirect.
module branch_resolve #(
  parameter int unsigned SHADOW = 2,
  parameter logic [31:0] MTVEC  = 32'h00000010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_flush,
  input  logic        ex_mb__valid,
  input  logic [31:0] ex_mb__pc,
  input  logic [31:0] ex_mb__pc_4,
  input  logic [31:0] ex_mb__imm,
  input  logic [31:0] ex_mb__rs1,
  input  logic [31:0] ex_mb__rs2,
  input  logic        ex_mb__is_branch,
  input  logic        ex_mb__is_jal,
  input  logic        ex_mb__is_jalr,
  input  logic [2:0]  ex_mb__funct3,
  input  logic        ex_mb__trap,
  input  logic [3:0]  ex_mb__trap_cause,
  input  logic        ex_mb__predict_taken,
  input  logic [31:0] ex_mb__predict_target,
  output logic [31:0] mb_if__pc,
  output logic [31:0] mb_if__pc_4,
  output logic [31:0] mb_if__jump_target,
  output logic [31:0] mb_if__predict_target,
  output logic        mb_if__branch_taken,
  output logic        mb_if__trap_taken,
  output logic        mb_if__predict_taken,
  output logic [31:0] mepc,
  output logic [3:0]  mcause,
  output logic [31:0] ctr_branch,
  output logic [31:0] ctr_mispredict
);

  localparam logic [2:0] SHADOW_CNT = 3'(SHADOW);

  typedef enum logic {
    RUN,
    SQUASH
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [31:0] pc_q, pc_d, pc4_q, pc4_d, jt_q, jt_d, ptgt_q, ptgt_d;
  logic        bt_q, bt_d, tt_q, tt_d, pt_q, pt_d;
  logic [31:0] mepc_q, mepc_d;
  logic [3:0]  mcause_q, mcause_d;
  logic [31:0] ctr_branch_q, ctr_branch_d, ctr_mispredict_q, ctr_mispredict_d;

  logic        accept, cond, is_xfer, taken, trap, mispredict, redirect;
  logic [31:0] pc_sum, jalr_sum, target;
  logic [3:0]  cause;

  // Resolve condition, target, trap priority and mispredict for the current input
  always_comb begin
    accept = ex_mb__valid && !pipe_flush && (state_q == RUN);
    unique case (ex_mb__funct3)
      3'b000:  cond = (ex_mb__rs1 == ex_mb__rs2);
      3'b001:  cond = (ex_mb__rs1 != ex_mb__rs2);
      3'b100:  cond = ($signed(ex_mb__rs1) <  $signed(ex_mb__rs2));
      3'b101:  cond = ($signed(ex_mb__rs1) >= $signed(ex_mb__rs2));
      3'b110:  cond = (ex_mb__rs1 <  ex_mb__rs2);
      3'b111:  cond = (ex_mb__rs1 >= ex_mb__rs2);
      default: cond = 1'b0;
    endcase
    is_xfer  = ex_mb__is_branch || ex_mb__is_jal || ex_mb__is_jalr;
    taken    = ex_mb__is_jal || ex_mb__is_jalr || (ex_mb__is_branch && cond);
    pc_sum   = ex_mb__pc + ex_mb__imm;
    jalr_sum = ex_mb__rs1 + ex_mb__imm;
    target   = ex_mb__is_jalr ? {jalr_sum[31:1], 1'b0} : pc_sum;

    trap  = 1'b1;
    cause = 4'd0;
    if (ex_mb__trap) begin
      cause = ex_mb__trap_cause;
    end else if (ex_mb__is_branch && (ex_mb__funct3[2:1] == 2'b01)) begin
      cause = 4'd2;
    end else if (taken && target[1]) begin
      cause = 4'd0;
    end else begin
      trap = 1'b0;
    end

    mispredict = (ex_mb__predict_taken != taken) ||
                 (taken && (ex_mb__predict_target != target));
    redirect   = accept && (trap || mispredict);
  end

  // Squash FSM next state: hold off acceptance for SHADOW cycles after a redirect
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          state_d = SQUASH;
          cnt_d   = SHADOW_CNT;
        end
      end
      SQUASH: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output, CSR and counter next state; flags pulse only for accepted inputs
  always_comb begin
    pc_d             = pc_q;
    pc4_d            = pc4_q;
    jt_d             = jt_q;
    ptgt_d           = ptgt_q;
    bt_d             = 1'b0;
    tt_d             = 1'b0;
    pt_d             = 1'b0;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    ctr_branch_d     = ctr_branch_q;
    ctr_mispredict_d = ctr_mispredict_q;
    if (accept) begin
      pc_d   = ex_mb__pc;
      pc4_d  = ex_mb__pc_4;
      ptgt_d = ex_mb__predict_target;
      if (trap) begin
        tt_d     = 1'b1;
        jt_d     = MTVEC;
        mepc_d   = ex_mb__pc;
        mcause_d = cause;
      end else begin
        bt_d = taken;
        pt_d = ex_mb__predict_taken;
        jt_d = target;
        if (is_xfer)    ctr_branch_d     = ctr_branch_q + 32'd1;
        if (mispredict) ctr_mispredict_d = ctr_mispredict_q + 32'd1;
      end
    end
  end

  // State and output registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      cnt_q            <= '0;
      pc_q             <= '0;
      pc4_q            <= '0;
      jt_q             <= '0;
      ptgt_q           <= '0;
      bt_q             <= 1'b0;
      tt_q             <= 1'b0;
      pt_q             <= 1'b0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      ctr_branch_q     <= '0;
      ctr_mispredict_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      pc_q             <= pc_d;
      pc4_q            <= pc4_d;
      jt_q             <= jt_d;
      ptgt_q           <= ptgt_d;
      bt_q             <= bt_d;
      tt_q             <= tt_d;
      pt_q             <= pt_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      ctr_branch_q     <= ctr_branch_d;
      ctr_mispredict_q <= ctr_mispredict_d;
    end
  end

  assign mb_if__pc             = pc_q;
  assign mb_if__pc_4           = pc4_q;
  assign mb_if__jump_target    = jt_q;
  assign mb_if__predict_target = ptgt_q;
  assign mb_if__branch_taken   = bt_q;
  assign mb_if__trap_taken     = tt_q;
  assign mb_if__predict_taken  = pt_q;
  assign mepc                  = mepc_q;
  assign mcause                = mcause_q;
  assign ctr_branch            = ctr_branch_q;
  assign ctr_mispredict        = ctr_mispredict_q;

endmodule
